// File: rtl/hazard_pkg.sv
//------------------------------------------------------------------------------
// Module   : hazard_pkg
// Desc     : Shared types and constants for the MIPS pipeline hazard controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   localparam int REG_ZERO = 0;

   localparam int WAIT_W = 8;
   localparam logic [WAIT_W-1:0] WAIT_SAT = 8'hFF;

endpackage : hazard_pkg

`default_nettype wire

// File: rtl/hazard_controller_forwarding_unit.sv
//------------------------------------------------------------------------------
// Module   : forwarding_unit
// Desc     : Combinational ALU operand forwarding selects for the EX stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module forwarding_unit
   import hazard_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] ex_rs,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             exmem_regwrite,
   input  logic [REG_W-1:0] exmem_rd,
   input  logic             memwb_regwrite,
   input  logic [REG_W-1:0] memwb_rd,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
);

   localparam logic [REG_W-1:0] ZERO_REG = REG_W'(REG_ZERO);

   // The younger producer (EX/MEM) takes precedence over MEM/WB.
   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
      logic [1:0] sel;
      sel = FWD_REG;
      if (exmem_regwrite && (exmem_rd != ZERO_REG) && (exmem_rd == src)) begin
         sel = FWD_EXMEM;
      end else if (memwb_regwrite && (memwb_rd != ZERO_REG) && (memwb_rd == src)) begin
         sel = FWD_MEMWB;
      end
      return sel;
   endfunction

   always_comb begin
      fwd_a = fwd_sel(ex_rs);
      fwd_b = fwd_sel(ex_rt);
   end

endmodule : forwarding_unit

`default_nettype wire

// File: rtl/hazard_controller.sv
//------------------------------------------------------------------------------
// Module   : hazard_controller
// Desc     : Five-stage MIPS pipeline sequencing: load-use stalls, branch/jump
//            redirects, data-memory wait freeze and operand forwarding.
//            Optional macro HAZARD_STALL_COUNTER_EN adds the stall_cycles port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_controller
   import hazard_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_jump,
   input  logic [REG_W-1:0] ex_rs,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_memread,
   input  logic             ex_branch_taken,
   input  logic             exmem_regwrite,
   input  logic             memwb_regwrite,
   input  logic [REG_W-1:0] exmem_rd,
   input  logic [REG_W-1:0] memwb_rd,
   input  logic             mem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             exmem_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_bubble,
   output logic             pc_redirect,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
`ifdef HAZARD_STALL_COUNTER_EN
   output logic [CNT_W-1:0] stall_cycles,
`endif
   output logic             mem_timeout
);

   localparam logic [REG_W-1:0]  ZERO_REG    = REG_W'(REG_ZERO);
   localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MAX_WAIT - 1);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;

   logic       freeze;
   logic       load_use;
   logic       load_use_stall;
   logic [1:0] fwd_a_raw;
   logic [1:0] fwd_b_raw;

   assign freeze   = mem_req & ~dmem_ready;
   assign load_use = ex_memread && (ex_rt != ZERO_REG) &&
                     ((id_uses_rs && (id_rs == ex_rt)) ||
                      (id_uses_rt && (id_rt == ex_rt)));
   // A taken branch discards the ID instruction, so its load-use is moot.
   assign load_use_stall = ~freeze & ~ex_branch_taken & load_use;

   forwarding_unit #(
      .REG_W(REG_W)
   ) u_forwarding_unit (
      .ex_rs         (ex_rs),
      .ex_rt         (ex_rt),
      .exmem_regwrite(exmem_regwrite),
      .exmem_rd      (exmem_rd),
      .memwb_regwrite(memwb_regwrite),
      .memwb_rd      (memwb_rd),
      .fwd_a         (fwd_a_raw),
      .fwd_b         (fwd_b_raw)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      case (state_q)
         RUN: begin
            if (freeze) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else begin
               if (wait_cnt_q != WAIT_SAT) begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
               if (wait_cnt_q == TIMEOUT_CNT) begin
                  mem_timeout_d = 1'b1;
               end
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Priority: freeze > branch redirect > load-use > jump redirect.
   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      exmem_write  = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;
      pc_redirect  = 1'b0;
      fwd_a        = fwd_a_raw;
      fwd_b        = fwd_b_raw;

      if (!rst_n) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         ifid_flush   = 1'b1;
         idex_flush   = 1'b1;
         memwb_bubble = 1'b1;
         fwd_a        = FWD_REG;
         fwd_b        = FWD_REG;
      end else if (freeze) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         memwb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
         pc_redirect = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
      end else if (load_use) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
      end else if (id_jump) begin
         pc_redirect = 1'b1;
         ifid_flush  = 1'b1;
      end
   end

   assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_STALL_COUNTER_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (freeze || load_use_stall) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
`else
   logic unused_stall;
   assign unused_stall = load_use_stall;
`endif

endmodule : hazard_controller

`default_nettype wire

// File: tb/tb_hazard_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_hazard_controller
// Desc     : Directed self-checking bench for hazard_controller (MAX_WAIT=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_controller;

   localparam int REG_W = 5;
   localparam int CNT_W = 32;

   logic             clk;
   logic             rst_n;
   logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, exmem_rd, memwb_rd;
   logic             id_uses_rs, id_uses_rt, id_jump;
   logic             ex_memread, ex_branch_taken;
   logic             exmem_regwrite, memwb_regwrite;
   logic             mem_req, dmem_ready;
   logic             pc_write, ifid_write, idex_write, exmem_write;
   logic             ifid_flush, idex_flush, memwb_bubble, pc_redirect;
   logic [1:0]       fwd_a, fwd_b;
   logic             mem_timeout;
`ifdef HAZARD_STALL_COUNTER_EN
   logic [CNT_W-1:0] stall_cycles;
`endif

   int n_checks;
   int n_fail;

   hazard_controller #(
      .REG_W   (REG_W),
      .MAX_WAIT(4),
      .CNT_W   (CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .id_uses_rs     (id_uses_rs),
      .id_uses_rt     (id_uses_rt),
      .id_jump        (id_jump),
      .ex_rs          (ex_rs),
      .ex_rt          (ex_rt),
      .ex_memread     (ex_memread),
      .ex_branch_taken(ex_branch_taken),
      .exmem_regwrite (exmem_regwrite),
      .memwb_regwrite (memwb_regwrite),
      .exmem_rd       (exmem_rd),
      .memwb_rd       (memwb_rd),
      .mem_req        (mem_req),
      .dmem_ready     (dmem_ready),
      .pc_write       (pc_write),
      .ifid_write     (ifid_write),
      .idex_write     (idex_write),
      .exmem_write    (exmem_write),
      .ifid_flush     (ifid_flush),
      .idex_flush     (idex_flush),
      .memwb_bubble   (memwb_bubble),
      .pc_redirect    (pc_redirect),
      .fwd_a          (fwd_a),
      .fwd_b          (fwd_b),
`ifdef HAZARD_STALL_COUNTER_EN
      .stall_cycles   (stall_cycles),
`endif
      .mem_timeout    (mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0;
      exmem_rd = '0; memwb_rd = '0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
      ex_memread = 1'b0; ex_branch_taken = 1'b0;
      exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
      mem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      clear_inputs();
      exmem_regwrite = 1'b1; exmem_rd = 5'd3; ex_rs = 5'd3;

      // Reset state, sampled before any clock edge
      #3;
      check_eq("rst_pc_write",   32'(pc_write),     32'd0);
      check_eq("rst_exmem_wr",   32'(exmem_write),  32'd0);
      check_eq("rst_ifid_flush", 32'(ifid_flush),   32'd1);
      check_eq("rst_idex_flush", 32'(idex_flush),   32'd1);
      check_eq("rst_bubble",     32'(memwb_bubble), 32'd1);
      check_eq("rst_fwd_a",      32'(fwd_a),        32'd0);
      check_eq("rst_timeout",    32'(mem_timeout),  32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("run_pc_write",   32'(pc_write),   32'd1);
      check_eq("run_ifid_flush", 32'(ifid_flush), 32'd0);
      check_eq("run_fwd_a_ex",   32'(fwd_a),      32'b10);

      // Load-use stall and its one-cycle extent
      @(negedge clk);
      clear_inputs();
      ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
      #1;
      check_eq("lu_pc_write",   32'(pc_write),   32'd0);
      check_eq("lu_ifid_write", 32'(ifid_write), 32'd0);
      check_eq("lu_idex_flush", 32'(idex_flush), 32'd1);
      check_eq("lu_idex_write", 32'(idex_write), 32'd1);
      @(negedge clk);
      ex_memread = 1'b0;
      #1;
      check_eq("lu_next_pc",    32'(pc_write),   32'd1);
      check_eq("lu_next_ifid",  32'(ifid_write), 32'd1);
      check_eq("lu_next_flush", 32'(idex_flush), 32'd0);

      // Register $0 never stalls
      @(negedge clk);
      ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      #1;
      check_eq("lu_zero_pc", 32'(pc_write), 32'd1);

      // Load-use beats jump; branch beats load-use
      @(negedge clk);
      ex_rt = 5'd7; id_rt = 5'd7; id_uses_rs = 1'b0; id_uses_rt = 1'b1; id_jump = 1'b1;
      #1;
      check_eq("lujmp_redirect", 32'(pc_redirect), 32'd0);
      check_eq("lujmp_ifflush",  32'(ifid_flush),  32'd0);
      check_eq("lujmp_pc",       32'(pc_write),    32'd0);
      @(negedge clk);
      id_jump = 1'b0; ex_branch_taken = 1'b1;
      #1;
      check_eq("br_redirect",  32'(pc_redirect), 32'd1);
      check_eq("br_idex_fl",   32'(idex_flush),  32'd1);
      check_eq("br_pc_write",  32'(pc_write),    32'd1);
      @(negedge clk);
      clear_inputs();
      id_jump = 1'b1;
      #1;
      check_eq("jmp_redirect", 32'(pc_redirect), 32'd1);
      check_eq("jmp_ifflush",  32'(ifid_flush),  32'd1);
      check_eq("jmp_idexfl",   32'(idex_flush),  32'd0);

      // Forwarding priority
      @(negedge clk);
      clear_inputs();
      ex_rs = 5'd9; exmem_rd = 5'd9; memwb_rd = 5'd9;
      exmem_regwrite = 1'b1; memwb_regwrite = 1'b1;
      #1;
      check_eq("fwd_a_exmem", 32'(fwd_a), 32'b10);
      check_eq("fwd_b_none",  32'(fwd_b), 32'b00);
      exmem_regwrite = 1'b0; ex_rt = 5'd9;
      #1;
      check_eq("fwd_a_memwb", 32'(fwd_a), 32'b01);
      check_eq("fwd_b_memwb", 32'(fwd_b), 32'b01);
      exmem_regwrite = 1'b1; ex_rs = 5'd0; ex_rt = 5'd0; exmem_rd = 5'd0; memwb_rd = 5'd0;
      #1;
      check_eq("fwd_a_zero", 32'(fwd_a), 32'b00);
      check_eq("fwd_b_zero", 32'(fwd_b), 32'b00);

      // Memory wait: three miss cycles, release in the ready cycle
      @(negedge clk);
      clear_inputs();
      mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("mw_pc_write", 32'(pc_write),     32'd0);
         check_eq("mw_exmem_wr", 32'(exmem_write),  32'd0);
         check_eq("mw_bubble",   32'(memwb_bubble), 32'd1);
         @(negedge clk);
      end
      dmem_ready = 1'b1;
      #1;
      check_eq("mw_rel_pc",     32'(pc_write),     32'd1);
      check_eq("mw_rel_bubble", 32'(memwb_bubble), 32'd0);
      @(negedge clk);
      clear_inputs();
      check_eq("mw_state_run", 32'(dut.state_q), 32'(hazard_pkg::RUN));
      check_eq("mw_timeout",   32'(mem_timeout), 32'd0);

      // Branch held during freeze, taken once memory is ready
      mem_req = 1'b1; ex_branch_taken = 1'b1;
      #1;
      check_eq("bf_redirect", 32'(pc_redirect), 32'd0);
      check_eq("bf_ifflush",  32'(ifid_flush),  32'd0);
      check_eq("bf_idexflush",32'(idex_flush),  32'd0);
      @(negedge clk);
      dmem_ready = 1'b1;
      #1;
      check_eq("bf_rel_redirect", 32'(pc_redirect), 32'd1);
      check_eq("bf_rel_ifflush",  32'(ifid_flush),  32'd1);
      check_eq("bf_rel_idexfl",   32'(idex_flush),  32'd1);

      // Timeout with MAX_WAIT=4: flag registers on the edge leaving wait_cnt==3
      @(negedge clk);
      clear_inputs();
      mem_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_eq("to_cnt2",     32'(dut.wait_cnt_q), 32'd2);
      check_eq("to_early",    32'(mem_timeout),    32'd0);
      @(negedge clk);
      @(negedge clk);
      check_eq("to_set",      32'(mem_timeout),    32'd1);
      check_eq("to_still_frz",32'(pc_write),       32'd0);
      @(negedge clk);
      @(negedge clk);
      dmem_ready = 1'b1;
      #1;
      check_eq("to_rel_pc",   32'(pc_write),       32'd1);
      @(negedge clk);
      clear_inputs();
      check_eq("to_sticky",   32'(mem_timeout),    32'd1);
      check_eq("to_state_run",32'(dut.state_q),    32'(hazard_pkg::RUN));

      // Asynchronous reset in the middle of MEM_WAIT
      mem_req = 1'b1;
      @(posedge clk);
      #2;
      check_eq("ar_pre_state", 32'(dut.state_q), 32'(hazard_pkg::MEM_WAIT));
      rst_n = 1'b0;
      #1;
      check_eq("ar_state",    32'(dut.state_q),    32'(hazard_pkg::RUN));
      check_eq("ar_cnt",      32'(dut.wait_cnt_q), 32'd0);
      check_eq("ar_timeout",  32'(mem_timeout),    32'd0);
      check_eq("ar_pc_write", 32'(pc_write),       32'd0);
      check_eq("ar_ifflush",  32'(ifid_flush),     32'd1);
      check_eq("ar_idexflush",32'(idex_flush),     32'd1);
      check_eq("ar_bubble",   32'(memwb_bubble),   32'd1);

      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_hazard_controller

`default_nettype wire
